// File: rtl/wb_led_arbiter_pkg.sv
// ============================================================================
// wb_led_arbiter_pkg : shared state, grant and default-size definitions
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_led_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] c_GRANT_NONE = 2'b00;
  localparam logic [1:0] c_GRANT_M0   = 2'b01;
  localparam logic [1:0] c_GRANT_M1   = 2'b10;

  localparam int unsigned c_DEF_TIMEOUT = 255;
  localparam int unsigned c_DEF_OUTW    = 4;

  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      ST_OWN0: return c_GRANT_M0;
      ST_OWN1: return c_GRANT_M1;
      default: return c_GRANT_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
// ============================================================================
// wb_arb_watchdog : outstanding-request counter and optional ack watchdog
// Optional timeout enabled by macro WB_ARB_TIMEOUT_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arb_watchdog
  import wb_led_arbiter_pkg::*;
#(
  parameter int unsigned OUTW    = c_DEF_OUTW,
  parameter int unsigned TIMEOUT = c_DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_accept,
  input  logic i_done,
  output logic o_full,
  output logic o_expire
);

  localparam logic [OUTW-1:0] c_MAX_OUT = '1;

  logic [OUTW-1:0] r_outst;
  logic            w_clear;

  assign w_clear = i_clear || o_expire;
  assign o_full  = (r_outst == c_MAX_OUT);

  // Saturates at both ends; an ack arriving with nothing outstanding is ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_clear) begin
      r_outst <= '0;
    end else if (i_accept && !i_done && !o_full) begin
      r_outst <= r_outst + 1'b1;
    end else if (!i_accept && i_done && (r_outst != '0)) begin
      r_outst <= r_outst - 1'b1;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned     c_WDW     = $clog2(TIMEOUT + 1);
  localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);

  logic [c_WDW-1:0] r_wd;
  logic             w_waiting;

  assign w_waiting = (r_outst != '0) && !i_done;
  assign o_expire  = w_waiting && (r_wd == c_WD_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || !w_waiting || o_expire) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end
`else
  assign o_expire = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/wb_led_arbiter.sv
// ============================================================================
// wb_led_arbiter : two-master round-robin pipelined Wishbone arbiter (LED slave)
// Optional slave watchdog enabled by macro WB_ARB_TIMEOUT_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_led_arbiter
  import wb_led_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned OUTW    = c_DEF_OUTW,
  parameter int unsigned TIMEOUT = c_DEF_TIMEOUT
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW-1:0]   i_m0_data,
  input  logic [DW/8-1:0] i_m0_sel,
  output logic            o_m0_ack,
  output logic            o_m0_stall,
  output logic            o_m0_err,
  output logic [DW-1:0]   o_m0_data,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW-1:0]   i_m1_data,
  input  logic [DW/8-1:0] i_m1_sel,
  output logic            o_m1_ack,
  output logic            o_m1_stall,
  output logic            o_m1_err,
  output logic [DW-1:0]   o_m1_data,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [AW-1:0]   o_s_addr,
  output logic [DW-1:0]   o_s_data,
  output logic [DW/8-1:0] o_s_sel,
  input  logic            i_s_ack,
  input  logic            i_s_stall,
  input  logic            i_s_err,
  input  logic [DW-1:0]   i_s_data,
  output logic [1:0]      o_grant
);

  arb_state_t r_state;
  logic       r_last;     // 1 = master 1 owned most recently
  logic       w_own0;
  logic       w_own1;
  logic       w_release;
  logic       w_accept;
  logic       w_done;
  logic       w_full;
  logic       w_expire;

  assign w_own0    = (r_state == ST_OWN0);
  assign w_own1    = (r_state == ST_OWN1);
  assign w_release = (w_own0 && !i_m0_cyc) || (w_own1 && !i_m1_cyc);
  assign w_accept  = o_s_stb && !i_s_stall;
  assign w_done    = i_s_ack || i_s_err;
  assign o_grant   = grant_of(r_state);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_m0_cyc && (!i_m1_cyc || r_last)) begin
            r_state <= ST_OWN0;
          end else if (i_m1_cyc) begin
            r_state <= ST_OWN1;
          end
        end
        ST_OWN0: begin
          if (!i_m0_cyc || w_expire) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b0;
          end
        end
        ST_OWN1: begin
          if (!i_m1_cyc || w_expire) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // STB is held back while full so the slave never sees a request the master thinks stalled.
  always_comb begin
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_addr   = '0;
    o_s_data   = '0;
    o_s_sel    = '0;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_stall = 1'b1;
    o_m0_data  = '0;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_stall = 1'b1;
    o_m1_data  = '0;
    if (w_own0) begin
      o_s_cyc    = i_m0_cyc && !w_expire;
      o_s_stb    = i_m0_cyc && i_m0_stb && !w_full && !w_expire;
      o_s_we     = i_m0_we;
      o_s_addr   = i_m0_addr;
      o_s_data   = i_m0_data;
      o_s_sel    = i_m0_sel;
      o_m0_stall = i_s_stall || w_full;
      o_m0_ack   = i_s_ack;
      o_m0_err   = i_s_err || w_expire;
      o_m0_data  = i_s_data;
    end else if (w_own1) begin
      o_s_cyc    = i_m1_cyc && !w_expire;
      o_s_stb    = i_m1_cyc && i_m1_stb && !w_full && !w_expire;
      o_s_we     = i_m1_we;
      o_s_addr   = i_m1_addr;
      o_s_data   = i_m1_data;
      o_s_sel    = i_m1_sel;
      o_m1_stall = i_s_stall || w_full;
      o_m1_ack   = i_s_ack;
      o_m1_err   = i_s_err || w_expire;
      o_m1_data  = i_s_data;
    end
  end

  wb_arb_watchdog #(
    .OUTW    (OUTW),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_release),
    .i_accept (w_accept),
    .i_done   (w_done),
    .o_full   (w_full),
    .o_expire (w_expire)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_led_arbiter.sv
// ============================================================================
// tb_wb_led_arbiter : directed scenarios plus randomized traffic against a
// cycle-level reference model of the two-master arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_led_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int OUTW    = 4;
  localparam int TIMEOUT = 8;
  localparam int MAXO    = (1 << OUTW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mcyc, mstb, mwe, mack, mstall, merr;
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwdat [2];
  logic [DW-1:0] mrdat [2];
  logic [SW-1:0] msel  [2];
  logic          s_cyc, s_stb, s_we, s_ack, s_stall, s_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdat, s_rdat;
  logic [SW-1:0] s_sel;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  wb_led_arbiter #(.AW(AW), .DW(DW), .OUTW(OUTW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cyc(mcyc[0]), .i_m0_stb(mstb[0]), .i_m0_we(mwe[0]), .i_m0_addr(maddr[0]),
    .i_m0_data(mwdat[0]), .i_m0_sel(msel[0]), .o_m0_ack(mack[0]), .o_m0_stall(mstall[0]),
    .o_m0_err(merr[0]), .o_m0_data(mrdat[0]),
    .i_m1_cyc(mcyc[1]), .i_m1_stb(mstb[1]), .i_m1_we(mwe[1]), .i_m1_addr(maddr[1]),
    .i_m1_data(mwdat[1]), .i_m1_sel(msel[1]), .o_m1_ack(mack[1]), .o_m1_stall(mstall[1]),
    .o_m1_err(merr[1]), .o_m1_data(mrdat[1]),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr),
    .o_s_data(s_wdat), .o_s_sel(s_sel), .i_s_ack(s_ack), .i_s_stall(s_stall),
    .i_s_err(s_err), .i_s_data(s_rdat), .o_grant(grant)
  );

  // Reference model: owner -1 = nobody, else master index
  int owner, last, outst, wd;
  bit mvalid, cur_full, cur_expire;
  int n_checks, n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic settle();
    bit done;
    #1;
    cur_full   = 1'b0;
    cur_expire = 1'b0;
    if (!mvalid) return;
    done     = s_ack || s_err;
    cur_full = (outst == MAXO);
`ifdef WB_ARB_TIMEOUT_EN
    cur_expire = (owner >= 0) && (outst > 0) && !done && (wd == TIMEOUT - 1);
`endif
    check_eq("grant", grant, (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00);
    if (owner < 0) begin
      check_eq("s_cyc_idle", s_cyc, 0);
      check_eq("s_stb_idle", s_stb, 0);
      check_eq("s_bus_idle", {s_we, s_addr, s_sel}, 0);
      check_eq("s_wdat_idle", s_wdat, 0);
    end else begin
      check_eq("s_cyc", s_cyc, mcyc[owner] && !cur_expire);
      if (!cur_full) check_eq("s_stb", s_stb, mcyc[owner] && mstb[owner] && !cur_expire);
      check_eq("s_bus", {s_we, s_addr, s_sel}, {mwe[owner], maddr[owner], msel[owner]});
      check_eq("s_wdat", s_wdat, mwdat[owner]);
    end
    for (int x = 0; x < 2; x++) begin
      if (x == owner) begin
        check_eq($sformatf("m%0d_stall", x), mstall[x], s_stall || cur_full);
        check_eq($sformatf("m%0d_ack", x), mack[x], s_ack);
        check_eq($sformatf("m%0d_err", x), merr[x], s_err || cur_expire);
        check_eq($sformatf("m%0d_rdat", x), mrdat[x], s_rdat);
      end else begin
        check_eq($sformatf("m%0d_stall", x), mstall[x], 1);
        check_eq($sformatf("m%0d_resp", x), {mack[x], merr[x], mrdat[x]}, 0);
      end
    end
  endtask

  task automatic advance();
    bit acc, done;
    @(posedge clk);
    done = s_ack || s_err;
    acc  = 1'b0;
    if (owner >= 0)
      acc = mcyc[owner] && mstb[owner] && !cur_full && !cur_expire && !s_stall;
    if (rst) begin
      owner = -1; last = 1; outst = 0; wd = 0; mvalid = 1'b1;
    end else if (mvalid) begin
      if (owner < 0) begin
        if (mcyc[0] && mcyc[1]) owner = (last == 0) ? 1 : 0;
        else if (mcyc[0])       owner = 0;
        else if (mcyc[1])       owner = 1;
      end else if (!mcyc[owner] || cur_expire) begin
        last = owner; owner = -1; outst = 0; wd = 0;
      end else begin
        wd = (outst > 0 && !done) ? wd + 1 : 0;
        if (acc && !done)                   outst++;
        else if (!acc && done && outst > 0) outst--;
      end
    end
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    mcyc = '0; mstb = '0; mwe = '0;
    for (int x = 0; x < 2; x++) begin
      maddr[x] = '0; mwdat[x] = '0; msel[x] = '0;
    end
    s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0; s_rdat = '0;
  endtask

  task automatic set_m(input int x, input bit cyc, input bit stb, input logic [DW-1:0] d);
    mcyc[x] = cyc; mstb[x] = stb; mwe[x] = 1'b1;
    mwdat[x] = d; msel[x] = 4'hF; maddr[x] = 32'h0000_0010;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; mvalid = 1'b0;
    owner = -1; last = 1; outst = 0; wd = 0;
    idle_inputs();
    rst = 1'b1;
    #1;
    tick();
    do_reset();
    tick();

    // Single write from master 0
    do_reset();
    set_m(0, 1, 1, 32'h15);
    settle(); check_eq("t1_req_grant", grant, 2'b00); check_eq("t1_req_stb", s_stb, 0); advance();
    settle(); check_eq("t1_grant", grant, 2'b01); check_eq("t1_sdata", s_wdat, 32'h15);
    check_eq("t1_sstb", s_stb, 1); check_eq("t1_m1stall", mstall[1], 1); advance();
    mstb[0] = 1'b0; s_ack = 1'b1; s_rdat = 32'hA5;
    settle(); check_eq("t1_ack", mack[0], 1); check_eq("t1_m1stall_b", mstall[1], 1); advance();
    s_ack = 1'b0; set_m(0, 0, 0, 0);
    tick(); tick();

    // Round-robin on ties
    do_reset();
    set_m(0, 1, 0, 0); set_m(1, 1, 0, 0);
    tick();
    settle(); check_eq("t2_tie1", grant, 2'b01); advance();
    mcyc = 2'b00; tick();
    mcyc = 2'b11;
    settle(); check_eq("t2_gap", grant, 2'b00); advance();
    settle(); check_eq("t2_tie2", grant, 2'b10); advance();
    mcyc = 2'b00; tick();
    mcyc = 2'b11; tick();
    settle(); check_eq("t2_tie3", grant, 2'b01); advance();
    mcyc = 2'b00; tick(); tick();

    // Master 1 burst while master 0 waits
    do_reset();
    set_m(1, 1, 0, 0); tick();
    set_m(1, 1, 1, 32'h01); tick();
    set_m(1, 1, 1, 32'h02); set_m(0, 1, 0, 0);
    settle(); check_eq("t3_m0stall_w2", mstall[0], 1); advance();
    set_m(1, 1, 1, 32'h04); tick();
    mstb[1] = 1'b0; s_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle(); check_eq("t3_m0stall_ack", mstall[0], 1); check_eq("t3_m1ack", mack[1], 1); advance();
    end
    s_ack = 1'b0; mcyc[1] = 1'b0;
    settle(); check_eq("t3_rel_grant", grant, 2'b10); advance();
    settle(); check_eq("t3_gap", grant, 2'b00); advance();
    settle(); check_eq("t3_m0_grant", grant, 2'b01); advance();
    mcyc = 2'b00; tick(); tick();

    // Slave never acknowledges
    do_reset();
    set_m(0, 1, 1, 32'h3C); tick();
    tick();
    mstb[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      settle();
`ifdef WB_ARB_TIMEOUT_EN
      check_eq("t4_err", merr[0], k == 8);
      check_eq("t4_scyc", s_cyc, k != 8);
`else
      check_eq("t4_err", merr[0], 0);
`endif
      advance();
    end
`ifdef WB_ARB_TIMEOUT_EN
    settle(); check_eq("t4_grant_after", grant, 2'b00); advance();
`else
    repeat (12) tick();
    settle(); check_eq("t4_hold_grant", grant, 2'b01); check_eq("t4_hold_cyc", s_cyc, 1); advance();
`endif
    set_m(0, 0, 0, 0); tick(); tick();

    // Reset in the middle of an owned burst
    do_reset();
    set_m(1, 1, 1, 32'h77); tick();
    tick(); tick();
    mstb[1] = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; s_ack = 1'b1;
    settle(); check_eq("t5_grant", grant, 2'b00); check_eq("t5_scyc", s_cyc, 0);
    check_eq("t5_acks", mack, 2'b00); advance();
    s_ack = 1'b0; set_m(1, 0, 0, 0); tick(); tick();

`ifndef WB_ARB_TIMEOUT_EN
    // Outstanding limit
    do_reset();
    set_m(0, 1, 1, 32'h0F); tick();
    for (int i = 0; i < 15; i++) begin
      settle(); check_eq("t6_stall_pre", mstall[0], 0); advance();
    end
    settle(); check_eq("t6_full_stall", mstall[0], 1); check_eq("t6_full_stb", s_stb, 0); advance();
    tick();
    s_ack = 1'b1; tick();
    s_ack = 1'b0;
    settle(); check_eq("t6_stall_drop", mstall[0], 0); advance();
    set_m(0, 0, 0, 0); tick(); tick();
`endif

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (!mcyc[x])         mcyc[x] = ($urandom % 4) == 0;
        else if (owner == x)  mcyc[x] = ($urandom % 10) != 0;
        mstb[x]  = mcyc[x] && ($urandom % 2);
        mwe[x]   = $urandom % 2;
        maddr[x] = $urandom;
        mwdat[x] = $urandom;
        msel[x]  = SW'($urandom);
      end
      s_stall = ($urandom % 4) == 0;
      s_rdat  = $urandom;
      s_ack   = 1'b0;
      s_err   = 1'b0;
      if (outst > 0) begin
        int r;
        r = $urandom % 8;
        s_ack = (r < 3);
        s_err = (r == 3);
      end
      rst = ($urandom % 500) == 0;
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
